// File: rtl/tri_bbox_setup.sv
// tri_bbox_setup
//   Triangle setup ahead of frag_iterator. Latches three fp16 vertices,
//   forms the axis-aligned bounding box, clamps it to the viewport and
//   either issues it (single-cycle nd) or drops it (single-cycle cull).
//
// Ports
//   clk                          rising-edge clock
//   rst                          synchronous reset, active low
//   tri_nd / us_rfd              upstream triangle strobe / ready
//   fp_x0..fp_y2                 vertex coordinates, fp16
//   ds_rfd                       downstream ready (examined only in ISSUE)
//   nd                           bounding box valid pulse
//   fp_min_x..fp_max_y           bounding box, fp16, held until next issue
//   cull                         triangle dropped pulse
module tri_bbox_setup #(
  parameter logic [15:0] VP_MIN_X = 16'h0000,
  parameter logic [15:0] VP_MAX_X = 16'h6100,
  parameter logic [15:0] VP_MIN_Y = 16'h0000,
  parameter logic [15:0] VP_MAX_Y = 16'h5F80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tri_nd,
  output logic        us_rfd,
  input  logic [15:0] fp_x0,
  input  logic [15:0] fp_y0,
  input  logic [15:0] fp_x1,
  input  logic [15:0] fp_y1,
  input  logic [15:0] fp_x2,
  input  logic [15:0] fp_y2,
  input  logic        ds_rfd,
  output logic        nd,
  output logic [15:0] fp_min_x,
  output logic [15:0] fp_max_x,
  output logic [15:0] fp_min_y,
  output logic [15:0] fp_max_y,
  output logic        cull
);

  typedef enum logic [2:0] {IDLE, BX, BY, CLAMP, ISSUE, CULL} state_t;

  state_t            state;
  logic [2:0][15:0]  vx, vy;
  logic [15:0]       mn_x, mx_x, mn_y, mx_y;
  logic              bad_x, bad_y;
  logic [15:0]       c_mn_x, c_mx_x, c_mn_y, c_mx_y;
  logic              empty;

  // Map fp16 onto an unsigned total order: negatives flipped entirely,
  // positives get the sign bit set. -0 lands just below +0.
  function automatic logic [15:0] key(input logic [15:0] v);
    return v[15] ? ~v : (v ^ 16'h8000);
  endfunction

  // On equal keys the first (lower-indexed) operand wins.
  function automatic logic [15:0] fmin(input logic [15:0] a, input logic [15:0] b);
    return (key(b) < key(a)) ? b : a;
  endfunction

  function automatic logic [15:0] fmax(input logic [15:0] a, input logic [15:0] b);
    return (key(b) > key(a)) ? b : a;
  endfunction

  function automatic logic nonfin(input logic [2:0][15:0] v);
    return (&v[0][14:10]) | (&v[1][14:10]) | (&v[2][14:10]);
  endfunction

  always_comb begin
    c_mn_x = fmax(mn_x, VP_MIN_X);
    c_mx_x = fmin(mx_x, VP_MAX_X);
    c_mn_y = fmax(mn_y, VP_MIN_Y);
    c_mx_y = fmin(mx_y, VP_MAX_Y);
    // min = max is a valid one-pixel-wide box; only strict inversion is empty
    empty  = (key(c_mn_x) > key(c_mx_x)) | (key(c_mn_y) > key(c_mx_y));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      us_rfd   <= 1'b1;
      nd       <= 1'b0;
      cull     <= 1'b0;
      fp_min_x <= 16'h0000;
      fp_max_x <= 16'h0000;
      fp_min_y <= 16'h0000;
      fp_max_y <= 16'h0000;
      vx       <= '0;
      vy       <= '0;
      mn_x     <= 16'h0000;
      mx_x     <= 16'h0000;
      mn_y     <= 16'h0000;
      mx_y     <= 16'h0000;
      bad_x    <= 1'b0;
      bad_y    <= 1'b0;
    end else begin
      nd   <= 1'b0;
      cull <= 1'b0;
      case (state)
        IDLE: if (tri_nd) begin
          vx     <= {fp_x2, fp_x1, fp_x0};
          vy     <= {fp_y2, fp_y1, fp_y0};
          us_rfd <= 1'b0;
          state  <= BX;
        end
        BX: begin
          mn_x  <= fmin(fmin(vx[0], vx[1]), vx[2]);
          mx_x  <= fmax(fmax(vx[0], vx[1]), vx[2]);
          bad_x <= nonfin(vx);
          state <= BY;
        end
        BY: begin
          mn_y  <= fmin(fmin(vy[0], vy[1]), vy[2]);
          mx_y  <= fmax(fmax(vy[0], vy[1]), vy[2]);
          bad_y <= nonfin(vy);
          state <= CLAMP;
        end
        CLAMP: begin
          if (bad_x | bad_y | empty) begin
            // box outputs deliberately left holding the last issued box
            cull  <= 1'b1;
            state <= CULL;
          end else begin
            fp_min_x <= c_mn_x;
            fp_max_x <= c_mx_x;
            fp_min_y <= c_mn_y;
            fp_max_y <= c_mx_y;
            state    <= ISSUE;
          end
        end
        ISSUE: if (ds_rfd) begin
          nd     <= 1'b1;
          us_rfd <= 1'b1;
          state  <= IDLE;
        end
        CULL: begin
          us_rfd <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          us_rfd <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_bbox_setup.sv
// Directed bench for tri_bbox_setup: basic box, back-to-back clamp,
// culls (empty / NaN), backpressure with ignored strobe, mid-op reset,
// signed-zero degenerate box.
module tb_tri_bbox_setup;

  logic        clk = 1'b0;
  logic        rst, tri_nd, ds_rfd;
  logic [15:0] fp_x0, fp_y0, fp_x1, fp_y1, fp_x2, fp_y2;
  logic        us_rfd, nd, cull;
  logic [15:0] fp_min_x, fp_max_x, fp_min_y, fp_max_y;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tri_bbox_setup dut (
    .clk(clk), .rst(rst), .tri_nd(tri_nd), .us_rfd(us_rfd),
    .fp_x0(fp_x0), .fp_y0(fp_y0), .fp_x1(fp_x1), .fp_y1(fp_y1),
    .fp_x2(fp_x2), .fp_y2(fp_y2), .ds_rfd(ds_rfd), .nd(nd),
    .fp_min_x(fp_min_x), .fp_max_x(fp_max_x),
    .fp_min_y(fp_min_y), .fp_max_y(fp_max_y), .cull(cull)
  );

  // advance one edge, settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_box(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    chk({tag, ".min_x"}, fp_min_x, a);
    chk({tag, ".max_x"}, fp_max_x, b);
    chk({tag, ".min_y"}, fp_min_y, c);
    chk({tag, ".max_y"}, fp_max_y, d);
  endtask

  // present a triangle for one cycle; returns after the accepting edge
  task automatic send(input logic [15:0] x0, input logic [15:0] y0, input logic [15:0] x1,
                      input logic [15:0] y1, input logic [15:0] x2, input logic [15:0] y2);
    fp_x0 = x0; fp_y0 = y0; fp_x1 = x1; fp_y1 = y1; fp_x2 = x2; fp_y2 = y2;
    tri_nd = 1'b1;
    step();
    tri_nd = 1'b0;
    chk("accept.us_rfd", {15'b0, us_rfd}, 16'd0);
  endtask

  // with ds_rfd=1: three quiet edges, then nd on the fourth
  task automatic expect_nd(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, ".nd_early"}, {15'b0, nd}, 16'd0);
    end
    step();
    chk({tag, ".nd"}, {15'b0, nd}, 16'd1);
    chk({tag, ".cull"}, {15'b0, cull}, 16'd0);
    chk({tag, ".us_rfd"}, {15'b0, us_rfd}, 16'd1);
    chk_box(tag, a, b, c, d);
  endtask

  // cull high in the cycle after the third edge, for one cycle only
  task automatic expect_cull(input string tag);
    step();
    step();
    chk({tag, ".cull_early"}, {15'b0, cull}, 16'd0);
    step();
    chk({tag, ".cull"}, {15'b0, cull}, 16'd1);
    chk({tag, ".nd"}, {15'b0, nd}, 16'd0);
    step();
    chk({tag, ".cull_off"}, {15'b0, cull}, 16'd0);
    chk({tag, ".nd_after"}, {15'b0, nd}, 16'd0);
    chk({tag, ".us_rfd"}, {15'b0, us_rfd}, 16'd1);
  endtask

  initial begin
    rst = 1'b0; tri_nd = 1'b0; ds_rfd = 1'b1;
    fp_x0 = 16'h0; fp_y0 = 16'h0; fp_x1 = 16'h0; fp_y1 = 16'h0; fp_x2 = 16'h0; fp_y2 = 16'h0;
    step();
    step();
    rst = 1'b1;

    // reset state
    chk("rst.us_rfd", {15'b0, us_rfd}, 16'd1);
    chk("rst.nd", {15'b0, nd}, 16'd0);
    chk("rst.cull", {15'b0, cull}, 16'd0);
    chk_box("rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // basic: (0.5,1.0) (2.0,0.25) (1.0,3.0)
    send(16'h3800, 16'h3C00, 16'h4000, 16'h3400, 16'h3C00, 16'h4200);
    expect_nd("basic", 16'h3800, 16'h4000, 16'h3400, 16'h4200);

    // clamp, accepted in the very cycle IDLE is re-entered
    send(16'hBC00, 16'h3800, 16'h3C00, 16'h3800, 16'h0000, 16'h6178);
    expect_nd("clamp", 16'h0000, 16'h3C00, 16'h3800, 16'h5F80);
    step();
    chk("clamp.nd_single", {15'b0, nd}, 16'd0);

    // all x negative -> empty after clamp; box outputs keep the clamp box
    send(16'hBC00, 16'h3C00, 16'hBC00, 16'h3C00, 16'hBC00, 16'h3C00);
    expect_cull("neg");
    chk_box("neg", 16'h0000, 16'h3C00, 16'h3800, 16'h5F80);

    // NaN x in an otherwise in-viewport triangle
    send(16'h3800, 16'h3C00, 16'h7E00, 16'h3400, 16'h3C00, 16'h4200);
    expect_cull("nan");

    // backpressure
    ds_rfd = 1'b0;
    send(16'h3800, 16'h3C00, 16'h4000, 16'h3400, 16'h3C00, 16'h4200);
    step(); step(); step();
    chk_box("bp.entry", 16'h3800, 16'h4000, 16'h3400, 16'h4200);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        fp_x0 = 16'h4400; fp_x1 = 16'h4500; fp_x2 = 16'h4600;
        tri_nd = 1'b1;
      end
      step();
      tri_nd = 1'b0;
      chk("bp.nd", {15'b0, nd}, 16'd0);
      chk("bp.us_rfd", {15'b0, us_rfd}, 16'd0);
      chk("bp.min_x", fp_min_x, 16'h3800);
      chk("bp.max_y", fp_max_y, 16'h4200);
    end
    ds_rfd = 1'b1;
    step();
    chk("bp.nd", {15'b0, nd}, 16'd1);
    chk_box("bp.out", 16'h3800, 16'h4000, 16'h3400, 16'h4200);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp.ignored_nd", {15'b0, nd}, 16'd0);
      chk("bp.ignored_cull", {15'b0, cull}, 16'd0);
    end

    // reset while in BY
    send(16'h3800, 16'h3C00, 16'h4000, 16'h3400, 16'h3C00, 16'h4200);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mrst.us_rfd", {15'b0, us_rfd}, 16'd1);
    chk("mrst.nd", {15'b0, nd}, 16'd0);
    chk_box("mrst", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mrst.nd_after", {15'b0, nd}, 16'd0);
      chk("mrst.cull_after", {15'b0, cull}, 16'd0);
    end

    // signed zero, degenerate box
    send(16'h0000, 16'h3C00, 16'h8000, 16'h3C00, 16'h0000, 16'h3C00);
    expect_nd("zero", 16'h0000, 16'h0000, 16'h3C00, 16'h3C00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
